// File: rtl/dma_program_mem_arbiter.sv
// dma_program_mem_arbiter: two-master burst arbiter in front of the single-port program/data RAM.
//
// Ports:
//   clk_i, reset_n_i                system clock, asynchronous active-low reset
//   m0_*_i / m1_*_i                 Avalon-MM style commands (address, burstcount, read, write,
//                                   byteenable, writedata) from the Nios II data master (m0)
//                                   and the DMA master (m1)
//   m0/m1_waitrequest_o             high while the command or beat is not accepted
//   m0/m1_readdatavalid_o           read beat valid, one cycle after the RAM read is issued
//   m_readdata_o                    shared read return bus, straight from the RAM
//   mem_*_o, mem_readdata_i         RAM slave port with 1-cycle read latency
//
// Build option: define DMA_ARB_ROUND_ROBIN_EN for round-robin contention handling;
// otherwise m0 has fixed priority.
module dma_program_mem_arbiter #(
    parameter int AW  = 14,
    parameter int DW  = 32,
    parameter int BCW = 4
) (
    input  logic            clk_i,
    input  logic            reset_n_i,
    input  logic [AW-1:0]   m0_address_i,
    input  logic [BCW-1:0]  m0_burstcount_i,
    input  logic            m0_read_i,
    input  logic            m0_write_i,
    input  logic [DW/8-1:0] m0_byteenable_i,
    input  logic [DW-1:0]   m0_writedata_i,
    output logic            m0_waitrequest_o,
    output logic            m0_readdatavalid_o,
    input  logic [AW-1:0]   m1_address_i,
    input  logic [BCW-1:0]  m1_burstcount_i,
    input  logic            m1_read_i,
    input  logic            m1_write_i,
    input  logic [DW/8-1:0] m1_byteenable_i,
    input  logic [DW-1:0]   m1_writedata_i,
    output logic            m1_waitrequest_o,
    output logic            m1_readdatavalid_o,
    output logic [DW-1:0]   m_readdata_o,
    output logic [AW-1:0]   mem_address_o,
    output logic [DW/8-1:0] mem_byteenable_o,
    output logic [DW-1:0]   mem_writedata_o,
    output logic            mem_chipselect_o,
    output logic            mem_write_o,
    input  logic [DW-1:0]   mem_readdata_i
);
    typedef enum logic [1:0] {IDLE, RBURST, WBURST} state_e;
    state_e         state_q, state_d;
    logic           owner_q, owner_d;
    logic [BCW-1:0] cnt_q, cnt_d;
    logic [AW-1:0]  addr_q, addr_d;
    logic           rdv_valid_q, rdv_owner_q;
    logic           req0, req1, sel, idle, accept, wbeat, beat_sel;
    logic [AW-1:0]  s_addr;
    logic [BCW-1:0] s_bc;
    logic           s_wr;

    assign req0 = m0_read_i | m0_write_i;
    assign req1 = m1_read_i | m1_write_i;
`ifdef DMA_ARB_ROUND_ROBIN_EN
    logic last_grant_q;
    // m1 wins contention only when m0 was granted last
    assign sel = req1 & (~req0 | ~last_grant_q);
`else
    assign sel = req1 & ~req0;
`endif

    assign idle   = state_q == IDLE;
    assign accept = idle & (req0 | req1);
    assign s_addr = sel ? m1_address_i : m0_address_i;
    assign s_bc   = sel ? m1_burstcount_i : m0_burstcount_i;
    // read+write together counts as a write
    assign s_wr   = sel ? m1_write_i : m0_write_i;
    assign wbeat  = state_q == WBURST & (owner_q ? m1_write_i : m0_write_i);
    assign beat_sel = idle ? sel : owner_q;

    assign mem_address_o    = idle ? s_addr : addr_q;
    assign mem_byteenable_o = beat_sel ? m1_byteenable_i : m0_byteenable_i;
    assign mem_writedata_o  = beat_sel ? m1_writedata_i : m0_writedata_i;
    assign mem_chipselect_o = accept | state_q == RBURST | wbeat;
    assign mem_write_o      = (accept & s_wr) | wbeat;
    assign m0_waitrequest_o = ~((accept & ~sel) | (wbeat & ~owner_q));
    assign m1_waitrequest_o = ~((accept & sel) | (wbeat & owner_q));
    assign m0_readdatavalid_o = rdv_valid_q & ~rdv_owner_q;
    assign m1_readdatavalid_o = rdv_valid_q & rdv_owner_q;
    assign m_readdata_o     = mem_readdata_i;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        // burstcount 0 and 1 are single beats handled entirely in IDLE
        if (accept && s_bc > BCW'(1)) begin
            state_d = s_wr ? WBURST : RBURST;
            owner_d = sel;
            addr_d  = s_addr + 1'b1;
            cnt_d   = s_bc - 1'b1;
        end else if (state_q == RBURST || wbeat) begin
            addr_d  = addr_q + 1'b1;
            cnt_d   = cnt_q - 1'b1;
            state_d = cnt_q == BCW'(1) ? IDLE : state_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            rdv_valid_q <= 1'b0;
            rdv_owner_q <= 1'b0;
`ifdef DMA_ARB_ROUND_ROBIN_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            rdv_valid_q <= mem_chipselect_o & ~mem_write_o;
            rdv_owner_q <= beat_sel;
`ifdef DMA_ARB_ROUND_ROBIN_EN
            if (accept) last_grant_q <= sel;
`endif
        end
    end
endmodule

// File: tb/tb_dma_program_mem_arbiter.sv
// tb_dma_program_mem_arbiter: scoreboard bench for the two-master RAM arbiter with a 1-cycle RAM model.
module tb_dma_program_mem_arbiter;
`ifdef DMA_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [13:0] m0_addr, m1_addr;
    logic [3:0]  m0_bc, m1_bc, m0_be, m1_be;
    logic        m0_rd, m0_wr, m1_rd, m1_wr;
    logic [31:0] m0_wd, m1_wd;
    logic        m0_wait, m1_wait, m0_rdv, m1_rdv;
    logic [31:0] m_readdata, mem_wd, mem_rdata;
    logic [13:0] mem_addr;
    logic [3:0]  mem_be;
    logic        mem_cs, mem_we;

    typedef struct {
        int          due;
        logic        own;
        logic [31:0] data;
    } exp_t;
    exp_t        sb[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    logic        lg = 1'b1;
    logic        w;
    logic [13:0] a;
    logic [31:0] ram [0:16383];

    dma_program_mem_arbiter dut (
        .clk_i(clk), .reset_n_i(reset_n),
        .m0_address_i(m0_addr), .m0_burstcount_i(m0_bc), .m0_read_i(m0_rd), .m0_write_i(m0_wr),
        .m0_byteenable_i(m0_be), .m0_writedata_i(m0_wd),
        .m0_waitrequest_o(m0_wait), .m0_readdatavalid_o(m0_rdv),
        .m1_address_i(m1_addr), .m1_burstcount_i(m1_bc), .m1_read_i(m1_rd), .m1_write_i(m1_wr),
        .m1_byteenable_i(m1_be), .m1_writedata_i(m1_wd),
        .m1_waitrequest_o(m1_wait), .m1_readdatavalid_o(m1_rdv),
        .m_readdata_o(m_readdata),
        .mem_address_o(mem_addr), .mem_byteenable_o(mem_be), .mem_writedata_o(mem_wd),
        .mem_chipselect_o(mem_cs), .mem_write_o(mem_we), .mem_readdata_i(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] f(input logic [13:0] x);
        return 32'h5A00_0000 ^ {10'd0, x, 8'd0} ^ {18'd0, x};
    endfunction

    initial for (int i = 0; i < 16384; i++) ram[i] = f(14'(i));

    always @(posedge clk) begin
        if (mem_cs) begin
            if (mem_we)
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) ram[mem_addr][8*b +: 8] <= mem_wd[8*b +: 8];
            mem_rdata <= ram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m0_rd = 0; m0_wr = 0; m1_rd = 0; m1_wr = 0;
        m0_addr = 0; m1_addr = 0; m0_bc = 1; m1_bc = 1;
        m0_be = 4'hF; m1_be = 4'hF; m0_wd = 0; m1_wd = 0;
    endtask

    // readdatavalid is checked every cycle: either the due scoreboard entry or silence
    task automatic sample();
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("rdv0", m0_rdv, !e.own);
            check("rdv1", m1_rdv, e.own);
            check("rdata", m_readdata, e.data);
        end else begin
            check("rdv0_quiet", m0_rdv, 0);
            check("rdv1_quiet", m1_rdv, 0);
        end
    endtask

    task automatic expect_read(input logic own, input logic [31:0] data);
        sb.push_back('{cyc + 1, own, data});
    endtask

    initial begin
        idle_all();
        repeat (2) @(posedge clk);
        #1 reset_n = 1;
        sample();
        check("rst_wait0", m0_wait, 1);
        check("rst_wait1", m1_wait, 1);
        check("rst_cs", mem_cs, 0);
        check("rst_we", mem_we, 0);
        step();
        // single-read contention
        m0_rd = 1; m0_addr = 14'h010; m1_rd = 1; m1_addr = 14'h020;
        for (int i = 0; i < 4; i++) begin
            sample();
            w = RR ? ~lg : 1'b0;
            a = w ? 14'h020 : 14'h010;
            check("b_wait0", m0_wait, w);
            check("b_wait1", m1_wait, !w);
            check("b_addr", mem_addr, a);
            check("b_we", mem_we, 0);
            expect_read(w, f(a));
            lg = w;
            step();
        end
        idle_all();
        sample();
        step();
        // read burst with address wrap; m0 queues behind it
        m1_rd = 1; m1_addr = 14'h3FFE; m1_bc = 4;
        sample();
        check("c_wait1", m1_wait, 0);
        check("c_addr0", mem_addr, 14'h3FFE);
        expect_read(1, f(14'h3FFE));
        lg = 1;
        step();
        m1_rd = 0; m0_rd = 1; m0_addr = 14'h007;
        for (int k = 1; k < 4; k++) begin
            sample();
            a = 14'h3FFE + 14'(k);
            check("c_wait0", m0_wait, 1);
            check("c_wait1", m1_wait, 1);
            check("c_cs", mem_cs, 1);
            check("c_addr", mem_addr, a);
            expect_read(1, f(a));
            step();
        end
        sample();
        check("c_next_wait0", m0_wait, 0);
        check("c_next_addr", mem_addr, 14'h007);
        expect_read(0, f(14'h007));
        lg = 0;
        step();
        idle_all();
        // write burst with a stall; owner read and m1 held meanwhile
        m0_wr = 1; m0_addr = 14'h100; m0_bc = 3; m0_wd = 32'hAAAA_0001;
        sample();
        check("d_wait0", m0_wait, 0);
        check("d_wait1", m1_wait, 1);
        check("d_we", mem_we, 1);
        check("d_addr", mem_addr, 14'h100);
        check("d_wd", mem_wd, 32'hAAAA_0001);
        lg = 0;
        step();
        m0_wr = 0; m0_rd = 1; m1_wr = 1; m1_addr = 14'h200; m1_wd = 32'hD1D1_D1D1;
        sample();
        check("d_stall_wait0", m0_wait, 1);
        check("d_stall_wait1", m1_wait, 1);
        check("d_stall_cs", mem_cs, 0);
        step();
        m0_rd = 0; m0_wr = 1; m0_addr = 14'h3AA; m0_wd = 32'hBBBB_0002; m0_be = 4'b0011;
        sample();
        check("d_b_wait0", m0_wait, 0);
        check("d_b_wait1", m1_wait, 1);
        check("d_b_addr", mem_addr, 14'h101);
        check("d_b_wd", mem_wd, 32'hBBBB_0002);
        check("d_b_be", mem_be, 4'b0011);
        step();
        m0_wd = 32'hCCCC_0003; m0_be = 4'hF;
        sample();
        check("d_c_wait1", m1_wait, 1);
        check("d_c_addr", mem_addr, 14'h102);
        check("d_c_wd", mem_wd, 32'hCCCC_0003);
        step();
        m0_wr = 0;
        sample();
        check("d_idle_wait1", m1_wait, 0);
        check("d_idle_addr", mem_addr, 14'h200);
        check("d_idle_we", mem_we, 1);
        lg = 1;
        step();
        idle_all();
        // continuous single-write contention
        m0_wr = 1; m0_addr = 14'h300; m0_wd = 32'hE0E0_E0E0;
        m1_wr = 1; m1_addr = 14'h301; m1_wd = 32'hE1E1_E1E1;
        for (int i = 0; i < 3; i++) begin
            sample();
            w = RR ? ~lg : 1'b0;
            check("e_wait0", m0_wait, w);
            check("e_wait1", m1_wait, !w);
            check("e_addr", mem_addr, w ? 14'h301 : 14'h300);
            check("e_wd", mem_wd, w ? 32'hE1E1_E1E1 : 32'hE0E0_E0E0);
            check("e_we", mem_we, 1);
            lg = w;
            step();
        end
        idle_all();
        // reset in the second cycle of an 8-beat read burst
        m0_rd = 1; m0_addr = 14'h040; m0_bc = 8;
        sample();
        check("f_wait0", m0_wait, 0);
        check("f_addr", mem_addr, 14'h040);
        step();
        m0_rd = 0; reset_n = 0;
        sb.delete();
        lg = 1;
        sample();
        check("f_rst_cs", mem_cs, 0);
        check("f_rst_we", mem_we, 0);
        step();
        reset_n = 1;
        m0_rd = 1; m0_addr = 14'h050; m0_bc = 1; m1_rd = 1; m1_addr = 14'h060;
        sample();
        check("f_post_wait0", m0_wait, 0);
        check("f_post_wait1", m1_wait, 1);
        check("f_post_addr", mem_addr, 14'h050);
        expect_read(0, f(14'h050));
        lg = 0;
        step();
        idle_all();
        // burstcount 0, then read back written words
        m0_rd = 1; m0_addr = 14'h005; m0_bc = 0;
        sample();
        check("g_wait0", m0_wait, 0);
        check("g_addr", mem_addr, 14'h005);
        check("g_cs", mem_cs, 1);
        expect_read(0, f(14'h005));
        step();
        m0_rd = 0; m1_rd = 1; m1_addr = 14'h101;
        sample();
        check("g_wait1", m1_wait, 0);
        check("g_rb_addr", mem_addr, 14'h101);
        expect_read(1, (f(14'h101) & 32'hFFFF_0000) | 32'h0000_0002);
        step();
        m1_rd = 0; m0_rd = 1; m0_addr = 14'h102;
        sample();
        check("g_rb2_wait0", m0_wait, 0);
        expect_read(0, 32'hCCCC_0003);
        step();
        idle_all();
        sample();
        check("g_quiet_cs", mem_cs, 0);
        step();
        sample();
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
